// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one WIDTH-bit delay-line stage with async reset and enable
module shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture the upstream sample on an enabled edge; reset clears at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - FIR sample history delay line with tap and fill-status outputs
module shift_register #(
  parameter int SIZE  = 10,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic [WIDTH-1:0]          reg_in,
  output logic [WIDTH-1:0]          reg_out,
  output logic [SIZE*WIDTH-1:0]     taps,
  output logic [$clog2(SIZE+1)-1:0] fill_count,
  output logic                      full
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(SIZE);

  logic [WIDTH-1:0] stage [SIZE];
  logic [CW-1:0]    count_next;

  // Stage 0 takes the new sample; every later stage takes its predecessor.
  for (genvar i = 0; i < SIZE; i++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (i == 0) begin : g_first
      assign d = reg_in;
    end else begin : g_next
      assign d = stage[i-1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .d   (d),
      .q   (stage[i])
    );

    assign taps[i*WIDTH +: WIDTH] = stage[i];
  end

  assign reg_out = stage[SIZE-1];

  // Count enabled shifts, stopping at SIZE so the MAC stage sees a stable "primed" value.
  always_comb begin
    count_next = fill_count;
    if (shift_en && (fill_count != FULL_COUNT)) begin
      count_next = fill_count + 1'b1;
    end
  end

  // full is registered from the same next-count so it changes on the same edge as the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count <= '0;
      full       <= 1'b0;
    end else begin
      fill_count <= count_next;
      full       <= (count_next == FULL_COUNT);
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - randomized self-checking bench for shift_register
module tb_shift_register;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shift_en = 1'b0;
  logic [7:0]  reg_in = 8'd0;

  logic [7:0]  reg_out;
  logic [79:0] taps;
  logic [3:0]  fill_count;
  logic        full;

  logic [7:0]  reg_out2;
  logic [15:0] taps2;
  logic [1:0]  fill_count2;
  logic        full2;

  int checks = 0;
  int errors = 0;

  // Reference history: index 0 newest, last index oldest.
  logic [7:0] m_hist  [$];
  logic [7:0] m2_hist [$];
  int         m_fill;
  int         m2_fill;

  shift_register #(.SIZE(10), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .reg_in     (reg_in),
    .reg_out    (reg_out),
    .taps       (taps),
    .fill_count (fill_count),
    .full       (full)
  );

  shift_register #(.SIZE(2), .WIDTH(8)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .reg_in     (reg_in),
    .reg_out    (reg_out2),
    .taps       (taps2),
    .fill_count (fill_count2),
    .full       (full2)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_hist.delete();
    m2_hist.delete();
    for (int i = 0; i < 10; i++) m_hist.push_back(8'd0);
    for (int i = 0; i < 2; i++) m2_hist.push_back(8'd0);
    m_fill  = 0;
    m2_fill = 0;
  endtask

  task automatic step(input logic en, input logic [7:0] din);
    @(negedge clk);
    shift_en = en;
    reg_in   = din;
    @(posedge clk);
    #1;
    if (en) begin
      m_hist.push_front(din);
      void'(m_hist.pop_back());
      m2_hist.push_front(din);
      void'(m2_hist.pop_back());
      if (m_fill < 10) m_fill++;
      if (m2_fill < 2) m2_fill++;
    end
    #1;
    reg_in = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    shift_en = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reg_in = 8'd22;
    shift_en = 1'b0;
    #2;
    checks++;
    if (reg_out !== 8'd0 || taps !== 80'd0 || fill_count !== 4'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_async out=%0h taps=%0h cnt=%0d full=%0b required all 0", reg_out, taps, fill_count, full);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      shift_en = (k == 2);
      checks++;
      if (reg_out !== 8'd0 || taps !== 80'd0 || fill_count !== 4'd0 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge%0d out=%0h cnt=%0d full=%0b required 0", k, reg_out, fill_count, full);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 80'd0 || fill_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_dominates taps=%0h cnt=%0d required 0", taps, fill_count);
    end
    @(negedge clk);
    shift_en = 1'b0;
    #3;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'd22);
      checks++;
      if (reg_out !== 8'd0 || taps !== 80'd0 || fill_count !== 4'd0 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge%0d out=%0h cnt=%0d required 0", k, reg_out, fill_count);
      end
    end
  endtask

  task automatic test_impulse();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, (k == 1) ? 8'd22 : 8'd0);
      checks++;
      if (reg_out !== ((k == 10) ? 8'd22 : 8'd0)) begin
        errors++;
        $display("FAIL impulse_out edge%0d got=%0d required=%0d", k, reg_out, (k == 10) ? 22 : 0);
      end
      if (k <= 10) begin
        checks++;
        if (taps[(k-1)*8 +: 8] !== 8'd22) begin
          errors++;
          $display("FAIL impulse_walk edge%0d stage%0d got=%0d required=22", k, k-1, taps[(k-1)*8 +: 8]);
        end
      end
      checks++;
      if (fill_count !== 4'((k < 10) ? k : 10) || full !== (k >= 10)) begin
        errors++;
        $display("FAIL impulse_fill edge%0d cnt=%0d full=%0b required cnt=%0d full=%0b", k, fill_count, full, (k < 10) ? k : 10, k >= 10);
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    step(1'b1, 8'd5);
    step(1'b1, 8'd6);
    step(1'b1, 8'd7);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(1'b0, 8'($urandom));
      checks++;
      if (taps[23:0] !== {8'd5, 8'd6, 8'd7} || fill_count !== 4'd3) begin
        errors++;
        $display("FAIL gating_hold gap%0d taps=%0h cnt=%0d required 050607 cnt=3", k, taps[23:0], fill_count);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8 + k));
      checks++;
      for (int i = 0; i < 10; i++) begin
        if (taps[i*8 +: 8] !== m_hist[i]) begin
          errors++;
          $display("FAIL gating_resume step%0d stage%0d got=%0d required=%0d", k, i, taps[i*8 +: 8], m_hist[i]);
        end
      end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int k = 1; k <= 12; k++) step(1'b1, 8'(k));
    checks++;
    for (int i = 0; i < 10; i++) begin
      if (taps[i*8 +: 8] !== 8'(12 - i)) begin
        errors++;
        $display("FAIL ramp_taps stage%0d got=%0d required=%0d", i, taps[i*8 +: 8], 12 - i);
      end
    end
    checks++;
    if (reg_out !== 8'd3 || fill_count !== 4'd10 || full !== 1'b1) begin
      errors++;
      $display("FAIL ramp_out out=%0d cnt=%0d full=%0b required 3 10 1", reg_out, fill_count, full);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    shift_en = 1'b1;
    reg_in = 8'd9;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (reg_out !== 8'd0 || taps !== 80'd0 || fill_count !== 4'd0 || full !== 1'b0 || taps2 !== 16'd0) begin
      errors++;
      $display("FAIL async_reset out=%0h taps=%0h cnt=%0d full=%0b required all 0", reg_out, taps, fill_count, full);
    end
    @(negedge clk);
    rst = 1'b0;
    shift_en = 1'b0;
    model_clear();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, (k == 1) ? 8'd22 : 8'd0);
      checks++;
      if (reg_out !== ((k == 10) ? 8'd22 : 8'd0)) begin
        errors++;
        $display("FAIL async_refill edge%0d got=%0d required=%0d", k, reg_out, (k == 10) ? 22 : 0);
      end
    end
  endtask

  task automatic test_full_scale();
    logic [7:0] pat [24];
    do_reset();
    for (int k = 0; k < 24; k++) begin
      pat[k] = (k % 2 == 0) ? 8'hFF : 8'h00;
      step(1'b1, pat[k]);
      checks++;
      if (reg_out !== ((k >= 9) ? pat[k-9] : 8'h00)) begin
        errors++;
        $display("FAIL fullscale10 edge%0d got=%0h required=%0h", k, reg_out, (k >= 9) ? pat[k-9] : 8'h00);
      end
      checks++;
      if (reg_out2 !== ((k >= 1) ? pat[k-1] : 8'h00)) begin
        errors++;
        $display("FAIL fullscale2 edge%0d got=%0h required=%0h", k, reg_out2, (k >= 1) ? pat[k-1] : 8'h00);
      end
    end
    checks++;
    if (fill_count2 !== 2'd2 || full2 !== 1'b1) begin
      errors++;
      $display("FAIL fullscale2_fill cnt=%0d full=%0b required 2 1", fill_count2, full2);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom));
      checks++;
      for (int i = 0; i < 10; i++) begin
        if (taps[i*8 +: 8] !== m_hist[i]) begin
          errors++;
          $display("FAIL random_taps step%0d stage%0d got=%0h required=%0h", k, i, taps[i*8 +: 8], m_hist[i]);
        end
      end
      if (reg_out !== m_hist[9] || fill_count !== 4'(m_fill) || full !== (m_fill == 10)) begin
        errors++;
        $display("FAIL random_status step%0d out=%0h cnt=%0d full=%0b required %0h %0d %0b", k, reg_out, fill_count, full, m_hist[9], m_fill, m_fill == 10);
      end
      checks++;
      if (taps2 !== {m2_hist[1], m2_hist[0]} || fill_count2 !== 2'(m2_fill) || full2 !== (m2_fill == 2)) begin
        errors++;
        $display("FAIL random_size2 step%0d taps=%0h cnt=%0d required %0h%0h %0d", k, taps2, fill_count2, m2_hist[1], m2_hist[0], m2_fill);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_enable_gating();
    test_ramp();
    test_async_reset();
    test_full_scale();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Parameterised delay line: SIZE stages, each WIDTH bits, advanced one stage per clock when shift_en is high.
- Serves as the sample history (tap delay line) of the FIR filter datapath.
- reg_out presents the oldest stage.
- Auxiliary outputs expose all taps and a fill status so the MAC stage can read history and know when it is primed.

Parameters:
- SIZE, default 10: number of stages (delay depth); legal range ≥ 2.
- WIDTH, default 8: bits per sample/stage; legal range ≥ 1.
- Parameter order: SIZE first, WIDTH second. Positional overrides rely on this order.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- shift_en  input  1  advance enable; one shift per rising clk edge while high.
- reg_in  input  WIDTH  new sample loaded into stage 0 on a shift.
- reg_out  output  WIDTH  content of stage SIZE-1 (oldest sample).
- taps  output  SIZE*WIDTH  flattened stage contents; bits [i*WIDTH +: WIDTH] = stage i.
- fill_count  output  $clog2(SIZE+1)  number of shifts since reset, saturating at SIZE.
- full  output  1  high when fill_count == SIZE.
- Port order: clk, rst, shift_en, reg_in, reg_out, taps, fill_count, full. The first five are connected positionally by existing users.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; clock port clk, reset port rst.
- Reset:
  - rst high clears all stages, taps, reg_out and fill_count to 0, and full to 0, immediately without waiting for a clock edge.
  - Reset dominates shift_en.
  - Reset asserted mid-operation discards all history.
- Shift (rising clk, rst low, shift_en high):
  - stage[0] <= reg_in.
  - stage[i] <= stage[i-1] for i = 1..SIZE-1.
  - The old stage[SIZE-1] is discarded.
- Hold: shift_en low means all stages and fill_count keep their values; reg_in is ignored.
- reg_in is sampled only at the rising edge. Changes between edges have no effect.
- Outputs are purely registered/combinational views of stage registers: no extra pipeline.
- Latency: a sample loaded at enabled edge k appears on reg_out after edge k+SIZE-1, i.e. SIZE enabled edges counting the load edge. Disabled cycles stretch this latency without loss of data.
- taps: stage 0 is the newest sample and stage SIZE-1 the oldest; all update in the same cycle as the shift.
- fill_count:
  - Increments by 1 on each enabled edge while < SIZE.
  - Saturates at SIZE (no wrap).
  - full = (fill_count == SIZE), registered-equivalent, with no glitches relative to the stages.
- Data is passed unmodified: no sign handling or arithmetic on samples.
- No X propagation after reset: every storage element has a reset value.

Decomposition:
- No shared package required.
- WIDTH and SIZE remain module parameters.
- The fill_count width is derived locally via $clog2(SIZE+1).
- One natural sub-module: shift_stage, a WIDTH-bit register with async active-high reset and enable. Generate SIZE instances chained stage[i-1] -> stage[i].
- Fill counter and taps flattening stay in the top module.

Test Plan:
- Reset: hold rst=1 with reg_in=22, shift_en=0, apply clock edges -> reg_out=0, taps all 0, fill_count=0, full=0. Release rst at 3 ns with shift_en=0 -> outputs stay 0 over several edges.
- Single impulse, SIZE=10, WIDTH=8:
  - Stimulus: assert shift_en for exactly one edge with reg_in=22, then reg_in=0 with shift_en held 1.
  - Required response: 22 appears at taps stage 0 immediately after the load edge and walks one stage per edge.
  - reg_out=22 exactly after the 10th enabled edge counting the load edge; reg_out=0 before that and again after the 11th.
  - full rises on the 10th enabled edge, and fill_count stays 10 afterwards.
- Enable gating:
  - Stimulus: load 5, 6, 7 on consecutive enabled edges, then drop shift_en for 4 edges while reg_in toggles.
  - Required response: taps stage0..2 = 7, 6, 5, unchanged throughout the gap.
  - On resume, shifting continues with no lost or duplicated samples.
- Ramp fill: shift in 1..12 continuously -> after 12 edges taps stage0..9 = 12..3 and reg_out=3. fill_count saturates at 10 (no wrap).
- Async reset mid-stream: assert rst between clock edges with shift_en=1 and full=1 -> all outputs 0 before the next edge. After release, the first 22 shifted in reaches reg_out only after 10 more enabled edges.
- Full-scale data: shift 8'hFF and 8'h00 alternately -> reg_out reproduces the pattern delayed by SIZE edges, with no bit corruption; repeat with a SIZE=2 instance.
